tcdm_rsp_buffer: RTL and testbench
==================================

// Module: tcdm_rsp_buffer
// PURPOSE
// - Credit-based response buffer placed directly upstream of one TCDM bank
//   (always-grant SRAM, read data 1 cycle after handshake, no r_ready).
// - Adds r_ready backpressure toward the initiator: issues a read only when
//   a FIFO slot is reserved for its response, so bank data is never dropped.
// - Passes writes through without a credit (the bank produces no write response).
// PARAMETERS
// - AddrWidth  32  request address width
// - DataWidth  32  wdata/rdata width; BE width = DataWidth/8
// - IdWidth    1   transaction id width
// - Depth      2   response FIFO entries = max outstanding reads; >=1, any integer
// PORTS
// - clk_i         in   1          clock, rising edge
// - rst_i         in   1          asynchronous active-high reset
// - in_req_i      in   1          initiator request
// - in_gnt_o      out  1          initiator grant
// - in_add_i      in   AddrWidth  address
// - in_wen_i      in   1          1=read, 0=write
// - in_data_i     in   DataWidth  write data
// - in_be_i       in   DataWidth/8  byte enables
// - in_id_i       in   IdWidth    request id
// - in_r_valid_o  out  1          response valid
// - in_r_ready_i  in   1          response ready
// - in_r_data_o   out  DataWidth  response data
// - in_r_id_o     out  IdWidth    response id
// - out_req_o/out_gnt_i/out_add_o/out_wen_o/out_data_o/out_be_o/out_id_o:
//   bank-side request, same widths, out_gnt_i in, rest out
// - out_r_valid_i in 1, out_r_data_i in DataWidth, out_r_id_i in IdWidth: bank response
// BEHAVIOUR
// - Request fields add/wen/data/be/id: combinational pass-through to out_*.
// - stall = in_wen_i & (credit_q == 0); out_req_o = in_req_i & ~stall;
//   in_gnt_o = out_gnt_i & ~stall. Writes never stall.
// - credit_q: width $clog2(Depth+1), reset Depth. rd_hs = out_req_o&out_gnt_i&in_wen_i,
//   pop = in_r_valid_o&in_r_ready_i. rd_hs only: -1; pop only: +1; both: unchanged.
// - Invariant: credit_q + fifo count + reads in flight == Depth.
// - FIFO: push on out_r_valid_i {r_data,r_id}; rd/wr pointers wrap Depth-1 -> 0;
//   count 0..Depth. Push and pop same cycle: count unchanged, both pointers advance.
// - in_r_valid_o = (count != 0); in_r_data_o/in_r_id_o = head entry, held stable
//   while in_r_valid_o & ~in_r_ready_i. Latency bank rvalid -> in_r_valid_o: 1 cycle.
// - Full (count==Depth) with credit 0: reads stall, writes proceed.
// - out_r_valid_i while full: impossible by credit; flagged by simulation assertion.
// - Reset (any time, incl. mid-burst): credit_q=Depth, count=0, pointers=0,
//   in_r_valid_o=0, in_r_data_o/in_r_id_o='0; the bank is reset concurrently,
//   pending responses are discarded. Combinational outputs follow their inputs.
// - After reset is released, state updates start on the first rising edge.
// CONFIGURATION
// - TCDM_RSP_BYPASS_EN defined: when count==0 and out_r_valid_i, the response
//   goes combinationally to in_r_*; if in_r_ready_i=1 it is consumed with no push,
//   0-cycle latency; else it is pushed as normal.
// - Undefined: every response is registered through the FIFO (1-cycle latency).
// - Credit accounting identical in both builds.
// TESTING
// - Depth=2, reads id 0,1 with r_ready=0: both granted; 3rd read gnt=0, out_req=0;
//   r_valid=1, r_data=1st word, id=0 stable for 5 cycles.
// - Same state, write issued: gnt=1 same cycle, credit stays 0.
// - r_ready pulse 1 cycle: id 0 popped, credit 0->1; held read granted next cycle.
// - Streaming reads with r_ready=1: one grant per cycle, r_valid 2 cycles after
//   request (1 cycle with TCDM_RSP_BYPASS_EN), data in issue order.
// - Same-cycle read grant and pop at credit 1: credit stays 1, count unchanged.
// - rst_i high with 2 entries held: next cycle r_valid=0, credit=2, gnt=1 for read.

Source files
------------

// File: rtl/tcdm_rsp_buffer.sv
// Credit-based response buffer in front of one TCDM bank: reads issue only with a reserved slot.
// Optional TCDM_RSP_BYPASS_EN forwards a response straight through when the FIFO is empty.
module tcdm_rsp_buffer #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned Depth     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_req_i,
    output logic                   in_gnt_o,
    input  logic [AddrWidth-1:0]   in_add_i,
    input  logic                   in_wen_i,
    input  logic [DataWidth-1:0]   in_data_i,
    input  logic [DataWidth/8-1:0] in_be_i,
    input  logic [IdWidth-1:0]     in_id_i,
    output logic                   in_r_valid_o,
    input  logic                   in_r_ready_i,
    output logic [DataWidth-1:0]   in_r_data_o,
    output logic [IdWidth-1:0]     in_r_id_o,
    output logic                   out_req_o,
    input  logic                   out_gnt_i,
    output logic [AddrWidth-1:0]   out_add_o,
    output logic                   out_wen_o,
    output logic [DataWidth-1:0]   out_data_o,
    output logic [DataWidth/8-1:0] out_be_o,
    output logic [IdWidth-1:0]     out_id_o,
    input  logic                   out_r_valid_i,
    input  logic [DataWidth-1:0]   out_r_data_i,
    input  logic [IdWidth-1:0]     out_r_id_i
);
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CntWidth-1:0] credit_q, credit_d, count_q, count_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DataWidth-1:0] data_q [Depth];
    logic [IdWidth-1:0]   id_q   [Depth];

    logic stall, rd_hs, pop, push, pop_fifo, fifo_empty, fifo_full;

    assign out_add_o  = in_add_i;
    assign out_wen_o  = in_wen_i;
    assign out_data_o = in_data_i;
    assign out_be_o   = in_be_i;
    assign out_id_o   = in_id_i;

    assign stall     = in_wen_i & (credit_q == '0);
    assign out_req_o = in_req_i & ~stall;
    assign in_gnt_o  = out_gnt_i & ~stall;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntWidth'(Depth));

`ifdef TCDM_RSP_BYPASS_EN
    // An empty FIFO lets the bank response through combinationally; it is stored only if refused.
    assign in_r_valid_o = ~fifo_empty | out_r_valid_i;
    assign in_r_data_o  = fifo_empty ? out_r_data_i : data_q[rd_ptr_q];
    assign in_r_id_o    = fifo_empty ? out_r_id_i : id_q[rd_ptr_q];
    assign push         = out_r_valid_i & ~(fifo_empty & in_r_ready_i);
    assign pop_fifo     = ~fifo_empty & in_r_ready_i;
`else
    assign in_r_valid_o = ~fifo_empty;
    assign in_r_data_o  = data_q[rd_ptr_q];
    assign in_r_id_o    = id_q[rd_ptr_q];
    assign push         = out_r_valid_i;
    assign pop_fifo     = ~fifo_empty & in_r_ready_i;
`endif

    assign rd_hs = out_req_o & out_gnt_i & in_wen_i;
    assign pop   = in_r_valid_o & in_r_ready_i;

    always_comb begin
        credit_d = credit_q;
        unique case ({rd_hs, pop})
            2'b10:   credit_d = credit_q - CntWidth'(1);
            2'b01:   credit_d = credit_q + CntWidth'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push && !pop_fifo) begin
            count_d = count_q + CntWidth'(1);
        end else if (pop_fifo && !push) begin
            count_d = count_q - CntWidth'(1);
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (pop_fifo) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_q <= CntWidth'(Depth);
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            credit_q <= credit_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= out_r_data_i;
                id_q[wr_ptr_q]   <= out_r_id_i;
            end
        end
    end

`ifndef SYNTHESIS
    // Credits guarantee a slot for every response; a response into a full FIFO is a protocol bug.
    rsp_into_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(out_r_valid_i && fifo_full));
`endif

endmodule

// File: tb/tb_tcdm_rsp_buffer.sv
// Randomised bench for tcdm_rsp_buffer: a bank model drives responses and an
// issue-order queue with per-response ready times predicts every output.
module tb_tcdm_rsp_buffer;
    localparam int unsigned Depth = 2;
`ifdef TCDM_RSP_BYPASS_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 2;
`endif

    logic        clk, rst;
    logic        in_req, in_gnt, in_wen, in_r_valid, in_r_ready, in_id, in_r_id;
    logic [31:0] in_add, in_data, in_r_data;
    logic [3:0]  in_be;
    logic        out_req, out_gnt, out_wen, out_id, out_r_valid, out_r_id;
    logic [31:0] out_add, out_data, out_r_data;
    logic [3:0]  out_be;

    tcdm_rsp_buffer #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(1), .Depth(Depth)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_data_i(in_data), .in_be_i(in_be), .in_id_i(in_id),
        .in_r_valid_o(in_r_valid), .in_r_ready_i(in_r_ready), .in_r_data_o(in_r_data),
        .in_r_id_o(in_r_id),
        .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_data_o(out_data), .out_be_o(out_be), .out_id_o(out_id),
        .out_r_valid_i(out_r_valid), .out_r_data_i(out_r_data), .out_r_id_i(out_r_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bank_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Bank: always-grant SRAM, read data one cycle after the handshake, reset with the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r_valid <= 1'b0;
            out_r_data  <= '0;
            out_r_id    <= 1'b0;
        end else begin
            out_r_valid <= out_req & out_gnt & out_wen;
            out_r_data  <= bank_word(out_add);
            out_r_id    <= out_id;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        id;
        int          rdy;
    } rsp_t;

    rsp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input logic req, input logic wen, input logic [31:0] addr,
                        input logic id, input logic rr, input logic gnt);
        logic exp_gnt, exp_req, exp_rv, stall_e;
        int   credit_e;
        @(negedge clk);
        in_req     = req;
        in_wen     = wen;
        in_add     = addr;
        in_id      = id;
        in_r_ready = rr;
        out_gnt    = gnt;
        in_data    = $urandom;
        in_be      = 4'($urandom);
        #1;
        credit_e = Depth - q.size();
        stall_e  = wen && (credit_e == 0);
        exp_gnt  = gnt && !stall_e;
        exp_req  = req && !stall_e;
        exp_rv   = (q.size() > 0) && (q[0].rdy <= cyc);
        check("credit", 128'(dut.credit_q), 128'(credit_e));
        check("in_gnt", 128'(in_gnt), 128'(exp_gnt));
        check("out_req", 128'(out_req), 128'(exp_req));
        check("passthru", {out_add, out_wen, out_data, out_be, out_id},
              {in_add, in_wen, in_data, in_be, in_id});
        check("r_valid", 128'(in_r_valid), 128'(exp_rv));
        if (exp_rv) begin
            check("r_data", 128'(in_r_data), 128'(q[0].data));
            check("r_id", 128'(in_r_id), 128'(q[0].id));
        end
        @(posedge clk);
        if (req && exp_gnt && wen) q.push_back('{data: bank_word(addr), id: id, rdy: cyc + Lat});
        if (exp_rv && rr) void'(q.pop_front());
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        in_req     = 1'b0;
        in_wen     = 1'b1;
        in_r_ready = 1'b0;
        out_gnt    = 1'b1;
        #1;
        check("rst_r_valid", 128'(in_r_valid), 128'(0));
        check("rst_r_data", {in_r_data, in_r_id}, 128'(0));
        q.delete();
        @(negedge clk);
        in_req = 1'b1;
        #1;
        check("rst_credit", 128'(dut.credit_q), 128'(Depth));
        check("rst_gnt_rd", 128'(in_gnt), 128'(1));
        in_req = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_req = 1'b0; in_wen = 1'b0; in_add = '0; in_data = '0; in_be = '0;
        in_id = 1'b0; in_r_ready = 1'b0; out_gnt = 1'b1;
        do_reset();

        // Fill both credits, then a third read must stall while the head stays stable.
        step(1, 1, 32'h100, 0, 0, 1);
        step(1, 1, 32'h104, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h108, 0, 0, 1);
        step(1, 0, 32'h200, 0, 0, 1);
        step(1, 1, 32'h108, 0, 1, 1);
        step(1, 1, 32'h108, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h0, 0, 1, 1);

        // Streaming reads with r_ready held high.
        for (int i = 0; i < 8; i++) step(1, 1, 32'h300 + 32'(i * 4), 1'(i), 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h0, 0, 1, 1);

        // Reset while two responses sit in the FIFO.
        step(1, 1, 32'h400, 0, 0, 1);
        step(1, 1, 32'h404, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0, 0, 0, 1);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), ($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                 1'($urandom), ($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < 6; i++) step(0, 1, 32'h0, 0, 1, 1);
        check("drained", 128'(q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
